// File: rtl/ls_ahb_interface.sv
// LSU to AHB-Lite data-side master bridge.
// Sub-word stores are sequenced as a read followed by a write of the merged word.
module ls_ahb_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  hold_o,
    output logic                  bus_err_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic                  err_q;
    logic                  req;

    assign req = mem_re_i | mem_we_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_re_i)      state_d = S_RD_ADDR;
                else if (mem_we_i) state_d = S_WR_ADDR;
            end
            S_RD_ADDR: if (hready_i) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (hready_i) state_d = mem_we_i ? S_WR_ADDR : S_DONE;
            end
            S_WR_ADDR: if (hready_i) state_d = S_WR_DATA;
            S_WR_DATA: if (hready_i) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdata_q  <= '0;
            hwdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RD_DATA && hready_i) begin
                rdata_q <= hrdata_i;
                err_q   <= hresp_i;
            end
            if (state_q == S_WR_ADDR && hready_i) hwdata_q <= mem_wdata_i;
            // keep a read-phase error of an RMW visible through its write
            if (state_q == S_WR_DATA && hready_i) err_q <= err_q | hresp_i;
            if (state_q == S_DONE) err_q <= 1'b0;
        end
    end

    always_comb begin
        htrans_o = HTRANS_IDLE;
        hwrite_o = 1'b0;
        hold_o   = 1'b1;
        unique case (state_q)
            S_IDLE:    hold_o = req;
            S_RD_ADDR: htrans_o = HTRANS_NONSEQ;
            S_WR_ADDR: begin
                htrans_o = HTRANS_NONSEQ;
                hwrite_o = 1'b1;
            end
            S_DONE:    hold_o = 1'b0;
            default:   hold_o = 1'b1;
        endcase
    end

    assign bus_err_o   = (state_q == S_DONE) & err_q;
    assign mem_rdata_o = rdata_q;
    assign hwdata_o    = hwdata_q;
    assign haddr_o     = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign hsize_o     = 3'b010;
    assign hburst_o    = 3'b000;

endmodule

// File: tb/tb_ls_ahb_interface.sv
// Scoreboard bench for ls_ahb_interface: directed plan cases plus random
// loads, stores and RMWs against a zero/multi-wait AHB slave model.
module tb_ls_ahb_interface;

    typedef struct {
        int          ws;
        logic [31:0] rdata;
        logic        err;
    } ph_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hold;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_re_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic        hold_o, bus_err_o;
    logic [31:0] haddr_o, hwdata_o, hrdata_i;
    logic [1:0]  htrans_o;
    logic        hwrite_o, hready_i, hresp_i;
    logic [2:0]  hsize_o, hburst_o;

    ls_ahb_interface dut (
        .clk(clk), .rst_n(rst_n),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .hold_o(hold_o), .bus_err_o(bus_err_o),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
        .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
        .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
    );

    always #5 clk = ~clk;

    ph_t   slv_q[$];
    bus_t  exp_bus_q[$];
    done_t exp_done_q[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // AHB slave: one data phase per accepted address phase
    initial begin
        ph_t p;
        hready_i = 1'b1;
        hresp_i  = 1'b0;
        hrdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst_n && htrans_o == 2'b10 && hready_i) begin
                if (slv_q.size() > 0) p = slv_q.pop_front();
                else p = '{0, 32'h0BAD_0BAD, 1'b0};
                @(posedge clk); #1;
                for (int i = 0; i < p.ws; i++) begin
                    hready_i = 1'b0;
                    hrdata_i = $urandom;
                    @(posedge clk); #1;
                end
                hready_i = 1'b1;
                hrdata_i = p.rdata;
                hresp_i  = p.err;
                @(posedge clk); #1;
                hresp_i  = 1'b0;
                hrdata_i = $urandom;
            end
        end
    end

    // bus monitor: address phases and write data against expected transfers
    logic        wpend = 1'b0;
    logic [31:0] wexp, rd_snap;
    always @(negedge clk) begin
        bus_t b;
        if (!rst_n) begin
            wpend = 1'b0;
        end else begin
            if (wpend && hready_i) begin
                chk("hwdata", hwdata_o, wexp);
                chk("rdata_stable_wr", mem_rdata_o, rd_snap);
                wpend = 1'b0;
            end
            if (htrans_o == 2'b10 && hready_i) begin
                if (exp_bus_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_nonseq: got addr %08h expected none", haddr_o);
                end else begin
                    b = exp_bus_q.pop_front();
                    chk("haddr", haddr_o, b.addr);
                    chk("hwrite", {31'b0, hwrite_o}, {31'b0, b.wr});
                    chk("hsize_hburst", {26'b0, hsize_o, hburst_o}, 32'h10);
                    if (b.wr) begin
                        wpend   = 1'b1;
                        wexp    = b.wdata;
                        rd_snap = mem_rdata_o;
                    end
                end
            end
        end
    end

    // completion monitor: a held access ends on the first cycle hold drops
    logic prev_hold = 1'b0;
    int   hcnt = 0;
    always @(negedge clk) begin
        done_t d;
        if (!rst_n) begin
            prev_hold = 1'b0;
            hcnt = 0;
        end else begin
            if (prev_hold && !hold_o) begin
                if (exp_done_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    d = exp_done_q.pop_front();
                    chk("mem_rdata", mem_rdata_o, d.rdata);
                    chk("bus_err", {31'b0, bus_err_o}, {31'b0, d.err});
                    chk("hold_cycles", hcnt, d.hold);
                end
                hcnt = 0;
                done_cnt++;
            end else if (bus_err_o) begin
                n_vec++;
                n_bad++;
                $display("FAIL bus_err_stray: got 1 expected 0 at %0t", $time);
            end
            if (hold_o) hcnt++;
            prev_hold = hold_o;
        end
    end

    task automatic run_txn(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rws, input int wws, input logic rerr, input logic werr);
        ph_t   p;
        bus_t  b;
        done_t d;
        int    start;
        logic  ok;
        if (re) begin
            p = '{rws, rdata, rerr};
            slv_q.push_back(p);
            b = '{{addr[31:2], 2'b00}, 1'b0, 32'h0};
            exp_bus_q.push_back(b);
            last_rd = rdata;
        end
        if (we) begin
            p = '{wws, $urandom, werr};
            slv_q.push_back(p);
            b = '{{addr[31:2], 2'b00}, 1'b1, wdata};
            exp_bus_q.push_back(b);
        end
        d.rdata = last_rd;
        d.err   = (re & rerr) | (we & werr);
        d.hold  = (re && we) ? 5 + rws + wws : (re ? 3 + rws : 3 + wws);
        exp_done_q.push_back(d);
        mem_re_i    = re;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        start = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout: got no completion expected one within 100 cycles");
        end
    endtask

    initial begin
        logic [31:0] rd, wd, msk, a;
        int          kind;
        rst_n = 1'b0;
        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
        mem_addr_i = '0;
        mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_htrans", {30'b0, htrans_o}, 32'h0);
        chk("rst_hold", {31'b0, hold_o}, 32'h0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_hwdata", hwdata_o, 32'h0);
        chk("rst_buserr", {30'b0, bus_err_o, hwrite_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn(0, 1, 32'h0000_0020, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
        run_txn(1, 1, 32'h0000_0040, 32'hAABB_CC11, 32'hAABB_CCDD, 2, 0, 0, 0);
        run_txn(1, 0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 0);
        run_txn(1, 1, 32'h0000_0084, 32'h1111_2222, 32'h3333_4444, 0, 1, 1, 0);
        run_txn(1, 0, 32'h0000_0100, 32'h0, 32'h0102_0304, 0, 0, 0, 0);
        run_txn(1, 0, 32'h0000_0104, 32'h0, 32'h0506_0708, 1, 0, 0, 0);

        // reset while the write half of an RMW is on the bus
        mem_re_i = 1'b1;
        mem_we_i = 1'b1;
        mem_addr_i = 32'h40;
        mem_wdata_i = 32'h0000_0001;
        slv_q.push_back('{0, 32'h5555_AAAA, 1'b0});
        exp_bus_q.push_back('{32'h40, 1'b0, 32'h0});
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (htrans_o == 2'b10 && hwrite_o) break;
        end
        chk("rst_mid_wr_addr", {30'b0, htrans_o}, 32'h2);
        #1;
        rst_n = 1'b0;
        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
        #1;
        chk("rst_mid_htrans", {30'b0, htrans_o}, 32'h0);
        chk("rst_mid_hold", {31'b0, hold_o}, 32'h0);
        chk("rst_mid_rdata", mem_rdata_o, 32'h0);
        last_rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1, 0, 32'h0000_0200, 32'h0, 32'h7777_8888, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            a  = $urandom;
            rd = $urandom;
            if (kind == 0) begin
                mem_re_i = 1'b0;
                mem_we_i = 1'b0;
                mem_addr_i = a;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else if (kind == 1) begin
                run_txn(1, 0, a, $urandom, rd, $urandom_range(0, 3), 0,
                        ($urandom_range(0, 5) == 0), 0);
            end else if (kind == 2) begin
                run_txn(0, 1, a, $urandom, rd, 0, $urandom_range(0, 3),
                        0, ($urandom_range(0, 5) == 0));
            end else begin
                msk = a[0] ? 32'h0000_FF00 : 32'hFFFF_0000;
                wd  = (rd & ~msk) | ($urandom & msk);
                run_txn(1, 1, a, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            end
        end

        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bus_q_drained", exp_bus_q.size(), 32'h0);
        chk("done_q_drained", exp_done_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ls_ahb_interface.md
Name: ls_ahb_interface

Overview:
- Bridges the LSU's mem_re/mem_we/mem_addr/mem_wdata request lines to a single-master AHB-Lite port.
- Stalls the pipeline while a transfer is in flight.
- Sequences sub-word stores as read-then-write (read-modify-write, RMW): the LSU merges byte/half data into the word returned on mem_rdata_o, so that word must be fetched first.
- Sits directly downstream of the LSU; drives the data-side AHB master.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr_i and haddr_o.
- DATA_WIDTH, 32, width of all data buses; hsize_o is fixed at word size.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- mem_re_i  in  1  read request from LSU (level; stable while hold_o=1)
- mem_we_i  in  1  write request from LSU (level; re&we means RMW)
- mem_addr_i  in  ADDR_WIDTH  byte address from LSU
- mem_wdata_i  in  DATA_WIDTH  merged write word from LSU
- mem_rdata_o  out  DATA_WIDTH  registered read word (rdata_q)
- hold_o  out  1  pipeline stall request
- bus_err_o  out  1  one-cycle pulse: the completed access saw hresp_i=ERROR
- haddr_o  out  ADDR_WIDTH  AHB address, word aligned {mem_addr_i[ADDR_WIDTH-1:2],2'b00}
- htrans_o  out  2  AHB transfer type: IDLE=2'b00 or NONSEQ=2'b10 only
- hwrite_o  out  1  AHB write
- hsize_o  out  3  constant 3'b010 (word)
- hburst_o  out  3  constant 3'b000 (SINGLE)
- hwdata_o  out  DATA_WIDTH  AHB write data (hwdata_q)
- hrdata_i  in  DATA_WIDTH  AHB read data
- hready_i  in  1  AHB transfer ready
- hresp_i  in  1  AHB response (1 = ERROR)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rdata_q=0, hwdata_q=0, htrans_o=IDLE, hwrite_o=0, hold_o=0, bus_err_o=0. Reset mid-transfer aborts immediately; no completion is reported.
- Decoding: htrans_o/hwrite_o are decoded from the state register only. haddr_o is taken directly from mem_addr_i, which is stable while stalled.
- req = mem_re_i | mem_we_i.
- States and transitions:
  - IDLE: hold_o=req (combinational). Go to RD_ADDR if mem_re_i; else WR_ADDR if mem_we_i; else stay.
  - RD_ADDR: htrans=NONSEQ, hwrite=0, hold_o=1. Go to RD_DATA on hready_i, else stay.
  - RD_DATA: htrans=IDLE, hold_o=1. On hready_i: rdata_q<=hrdata_i, latch err. Then go to WR_ADDR if mem_we_i, else DONE.
  - WR_ADDR: htrans=NONSEQ, hwrite=1, hold_o=1. On hready_i: hwdata_q<=mem_wdata_i and go to WR_DATA.
  - WR_DATA: htrans=IDLE, hold_o=1. On hready_i: latch err and go to DONE.
  - DONE: hold_o=0, bus_err_o=err_q. Go to IDLE unconditionally; err_q is cleared. The pipeline advances on this edge.
- Back-to-back requests: after DONE, the next request is accepted in the IDLE cycle that follows. There is always exactly one IDLE cycle between accesses, which prevents re-issuing the same instruction.
- Latency with a zero-wait slave (cycles with hold_o=1):
  - Load: 3 (IDLE, RD_ADDR, RD_DATA).
  - Word store (we only): 3.
  - RMW: 5.
  - Each wait state (hready_i=0) adds one cycle to the current phase.
- ERROR response (hresp_i=1 with hready_i=1 in a data phase):
  - rdata_q still captures hrdata_i.
  - An RMW still performs its write.
  - bus_err_o pulses in DONE.
  - No retry.
- rdata_q holds its value outside RD_DATA completion. mem_rdata_o is therefore stable during WR_ADDR/WR_DATA, so the LSU merge stays consistent.
- Requests with neither re nor we are ignored; there is no bus activity.
- Changes on mem_* inputs while hold_o=1 are illegal; they are not checked.

Test Plan:
- Load, zero wait: mem_re_i=1, addr=0x0000_1006, slave returns 0xDEAD_BEEF.
  - haddr_o=0x0000_1004, NONSEQ/read for one cycle.
  - hold_o high 3 cycles.
  - mem_rdata_o=0xDEAD_BEEF in DONE; bus_err_o=0.
- Word store: mem_we_i=1, addr=0x20, wdata=0x1234_5678.
  - NONSEQ write at 0x20.
  - hwdata_o=0x1234_5678 in data phase; hold_o high 3 cycles.
- RMW with 2 wait states in read data phase: re=we=1, addr=0x40, hrdata=0xAABB_CCDD, LSU returns wdata 0xAABB_CC11.
  - Read then write to 0x40; hwdata_o=0xAABB_CC11.
  - hold_o high 7 cycles; mem_rdata_o stable through the write.
- Error: load with hresp_i=1, hready_i=1 in data phase.
  - bus_err_o=1 for exactly one cycle (DONE); FSM returns to IDLE.
- Reset mid-RMW: assert rst_n=0 during WR_ADDR.
  - Outputs go immediately to reset values (htrans IDLE, hold_o=0, mem_rdata_o=0).
  - After release, a fresh load completes normally.
- Back-to-back loads: two loads on consecutive pipeline advances.
  - Exactly one IDLE cycle between DONE and the second NONSEQ.
  - No duplicate transfer issued.
